// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit select encoding (common to dispatcher and result mux),
// dispatcher state encoding and the default operand width.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_CMP   = 2'b01;
    localparam logic [1:0] SEL_LOGIC = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/dispatch_timeout_ctr.sv
// WAIT-state cycle counter with clear, enable and a terminal-count flag at TIMEOUT-1.
module dispatch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/alu_op_dispatch.sv
// Routes one registered operation request to the selected ALU unit, waits for its
// done (or a timeout) and returns the 9-bit result with an error qualifier.
module alu_op_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              arith_start,
    output logic              cmp_start,
    output logic              logic_start,
    input  logic              arith_done,
    input  logic              cmp_done,
    input  logic              logic_done,
    input  logic [DATA_W:0]   arith_res,
    input  logic [DATA_W:0]   cmp_res,
    input  logic [DATA_W:0]   logic_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W:0]   res,
    output logic              err
);

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W:0]   res_q, res_d;
    logic              err_q, err_d;
    logic              unit_done;
    logic [DATA_W:0]   unit_res;
    logic              ctr_clr, ctr_en, ctr_tc;

    // Only the selected unit's done/result is visible; stray dones never reach the FSM.
    always_comb begin
        unit_done = 1'b0;
        unit_res  = '0;
        case (sel_q)
            SEL_ARITH: begin unit_done = arith_done; unit_res = arith_res; end
            SEL_CMP:   begin unit_done = cmp_done;   unit_res = cmp_res;   end
            SEL_LOGIC: begin unit_done = logic_done; unit_res = logic_res; end
            default:   begin unit_done = 1'b0;       unit_res = '0;        end
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        err_d   = err_q;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    sel_d  = sel;
                    op_a_d = a;
                    op_b_d = b;
                    if (sel == SEL_NONE) begin
                        res_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                ctr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked before the terminal count so a coincident done wins.
                if (unit_done) begin
                    res_d   = unit_res;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (ctr_tc) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    dispatch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    assign req_ready   = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign arith_start = (state_q == ST_ISSUE) && (sel_q == SEL_ARITH);
    assign cmp_start   = (state_q == ST_ISSUE) && (sel_q == SEL_CMP);
    assign logic_start = (state_q == ST_ISSUE) && (sel_q == SEL_LOGIC);
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign res         = res_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Directed table-driven bench for alu_op_dispatch plus hand sequences for reset mid-op.
module tb_alu_op_dispatch;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        sel;
    logic [DATA_W-1:0] a, b, op_a, op_b;
    logic              arith_start, cmp_start, logic_start;
    logic              arith_done, cmp_done, logic_done;
    logic [DATA_W:0]   arith_res, cmp_res, logic_res;
    logic              res_valid, res_ready, err;
    logic [DATA_W:0]   res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_dispatch #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .sel         (sel),
        .a           (a),
        .b           (b),
        .op_a        (op_a),
        .op_b        (op_b),
        .arith_start (arith_start),
        .cmp_start   (cmp_start),
        .logic_start (logic_start),
        .arith_done  (arith_done),
        .cmp_done    (cmp_done),
        .logic_done  (logic_done),
        .arith_res   (arith_res),
        .cmp_res     (cmp_res),
        .logic_res   (logic_res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .err         (err)
    );

    typedef struct {
        logic [1:0]        sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int                done_n;   // WAIT cycle (1-based) carrying the done; 0 = never
        logic [DATA_W:0]   ures;
        logic              stray;    // pulse non-selected dones every cycle
        int                hold;     // cycles res_ready stays low after res_valid
        logic [DATA_W:0]   exp_res;
        logic              exp_err;
        int                exp_lat;  // cycles from acceptance edge to res_valid
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_dones();
        arith_done = 1'b0; cmp_done = 1'b0; logic_done = 1'b0;
        arith_res  = '0;   cmp_res  = '0;   logic_res  = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat = 0;
        int na = 0, nc = 0, nl = 0;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({t, " req_ready idle"}, req_ready, 1);
        req_valid = 1'b1; sel = v.sel; a = v.a; b = v.b;
        @(negedge clk);
        req_valid = 1'b0; sel = 2'b00; a = '0; b = '0;
        chk({t, " op_a"}, op_a, v.a);
        chk({t, " op_b"}, op_b, v.b);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            na += int'(arith_start);
            nc += int'(cmp_start);
            nl += int'(logic_start);
            if (res_valid) begin
                lat = cyc;
                break;
            end
            clear_dones();
            if (v.stray) begin
                if (v.sel != 2'b00) begin arith_done = 1'b1; arith_res = 9'h1AA; end
                if (v.sel != 2'b01) begin cmp_done   = 1'b1; cmp_res   = 9'h1AA; end
                if (v.sel != 2'b10) begin logic_done = 1'b1; logic_res = 9'h1AA; end
            end
            if (v.done_n != 0 && cyc == 1 + v.done_n) begin
                case (v.sel)
                    2'b00:   begin arith_done = 1'b1; arith_res = v.ures; end
                    2'b01:   begin cmp_done   = 1'b1; cmp_res   = v.ures; end
                    default: begin logic_done = 1'b1; logic_res = v.ures; end
                endcase
            end
            @(negedge clk);
        end
        clear_dones();
        chk({t, " latency"}, lat, v.exp_lat);
        chk({t, " arith_start pulses"}, na, (v.sel == 2'b00) ? 1 : 0);
        chk({t, " cmp_start pulses"},   nc, (v.sel == 2'b01) ? 1 : 0);
        chk({t, " logic_start pulses"}, nl, (v.sel == 2'b10) ? 1 : 0);
        chk({t, " res"}, res, v.exp_res);
        chk({t, " err"}, err, v.exp_err);
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'b1; sel = 2'b00;
            @(negedge clk);
            chk({t, " hold res_valid"}, res_valid, 1);
            chk({t, " hold res"}, res, v.exp_res);
            chk({t, " hold err"}, err, v.exp_err);
            chk({t, " hold req_ready"}, req_ready, 0);
            chk({t, " hold no start"}, {arith_start, cmp_start, logic_start}, 0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({t, " res_valid after handoff"}, res_valid, 0);
        chk({t, " req_ready after handoff"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //             sel    a      b      dn  ures    str hold exp_res exp_err lat
        vecs[0] = '{2'b00, 8'h7F, 8'h01,  1, 9'h080, 1'b0, 0, 9'h080, 1'b0,  3};
        vecs[1] = '{2'b11, 8'hAA, 8'h55,  0, 9'h000, 1'b0, 5, 9'h000, 1'b0,  1};
        vecs[2] = '{2'b01, 8'h12, 8'h34,  0, 9'h000, 1'b0, 0, 9'h000, 1'b1, 18};
        vecs[3] = '{2'b00, 8'h01, 8'h02,  1, 9'h003, 1'b0, 0, 9'h003, 1'b0,  3};
        vecs[4] = '{2'b10, 8'hF0, 8'hFF,  3, 9'h0F0, 1'b1, 0, 9'h0F0, 1'b0,  5};
        vecs[5] = '{2'b01, 8'h00, 8'h00, 16, 9'h1FF, 1'b0, 0, 9'h1FF, 1'b0, 18};
        vecs[6] = '{2'b01, 8'h03, 8'h03, 15, 9'h101, 1'b1, 2, 9'h101, 1'b0, 17};
        vecs[7] = '{2'b10, 8'h3C, 8'hC3,  0, 9'h000, 1'b1, 0, 9'h000, 1'b1, 18};

        reset = 1'b1; req_valid = 1'b0; sel = 2'b00; a = '0; b = '0;
        res_ready = 1'b0;
        clear_dones();
        repeat (2) @(negedge clk);
        chk("reset req_ready", req_ready, 1);
        chk("reset res_valid", res_valid, 0);
        chk("reset res", res, 0);
        chk("reset err", err, 0);
        chk("reset op_a", op_a, 0);
        chk("reset op_b", op_b, 0);
        chk("reset starts", {arith_start, cmp_start, logic_start}, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during WAIT abandons the request; a late done is ignored.
        @(negedge clk);
        req_valid = 1'b1; sel = 2'b00; a = 8'h5A; b = 8'hC3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst-mid arith_start", arith_start, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst-mid req_ready", req_ready, 1);
        chk("rst-mid res_valid", res_valid, 0);
        chk("rst-mid op_a", op_a, 0);
        chk("rst-mid op_b", op_b, 0);
        chk("rst-mid res", res, 0);
        chk("rst-mid err", err, 0);
        arith_done = 1'b1; arith_res = 9'h1FF;
        @(negedge clk);
        clear_dones();
        for (int i = 0; i < 5; i++) begin
            chk("rst-mid late done res_valid", res_valid, 0);
            chk("rst-mid late done req_ready", req_ready, 1);
            chk("rst-mid late done starts", {arith_start, cmp_start, logic_start}, 0);
            @(negedge clk);
        end

        run_vec(vecs[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_dispatch.md
Name: alu_op_dispatch

Overview:
- Demultiplexing counterpart of the ALU result-select mux: accepts one operation request, routes registered operands to exactly one functional unit (arithmetic, compare, logic), waits for that unit's completion, and returns its 9-bit result (8-bit value plus carry/flag bit).
- Sits between the control/sequencer front end and the three ALU units.
- Uses the same select encoding as the result mux, so one select value drives both ends.

Parameters:
- DATA_W, 8, operand width; result width is DATA_W+1.
- TIMEOUT, 16, number of WAIT-state cycles without a done before the request is aborted; legal range 2..255.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  dispatcher can accept a request; high only in IDLE.
- sel  input  2  unit select: 00 arith, 01 compare, 10 logic, 11 none.
- a  input  DATA_W  operand A.
- b  input  DATA_W  operand B.
- op_a  output  DATA_W  registered operand A, broadcast to all units.
- op_b  output  DATA_W  registered operand B, broadcast to all units.
- arith_start, cmp_start, logic_start  output  1 each  one-cycle start strobes; at most one is high in any cycle.
- arith_done, cmp_done, logic_done  input  1 each  unit completion pulses.
- arith_res, cmp_res, logic_res  input  DATA_W+1 each  unit results, valid with the matching done.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res  output  DATA_W+1  returned result.
- err  output  1  qualifies res; 1 means the request timed out.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state goes to IDLE.
  - req_ready=1; all start strobes=0; res_valid=0; res=0; err=0; op_a=op_b=0; timeout counter=0.
  - Reset asserted mid-operation abandons the request with no result. A late done after reset is ignored.
- IDLE:
  - On req_valid & req_ready: register sel, a, b into sel_q, op_a, op_b.
  - If sel==11: go to DONE with res=0, err=0 (matches the mux's zero output for select 11).
  - Otherwise go to ISSUE.
- ISSUE (one cycle):
  - Assert the start strobe selected by sel_q for exactly this cycle.
  - Clear the counter; go to WAIT.
  - Done inputs are not sampled in ISSUE.
- WAIT:
  - If the done of the selected unit is high: capture that unit's result into res, set err=0, go to DONE.
  - Done pulses from non-selected units are ignored; they do not affect res, err or state.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no done, set res=0, err=1, go to DONE.
  - If done and timeout coincide in the same cycle, done wins (err=0).
- DONE:
  - res_valid=1; res and err are held stable until res_ready.
  - On res_ready: res_valid drops next cycle and state returns to IDLE.
  - req_ready stays 0 throughout DONE, so no new request is accepted in the same cycle as result handoff.
- Latency, with acceptance at edge k:
  - sel=11: res_valid in cycle k+1.
  - Unit sel with done in the first WAIT cycle: start strobe in k+1, WAIT in k+2, res_valid in k+3.
  - Minimum turnaround for unit ops is 4 cycles per request.
- op_a and op_b hold their values from acceptance until the next acceptance.
- Counter width is clog2(TIMEOUT); it never wraps because it is cleared on entry to WAIT.

Decomposition:
- Shared package alu_pkg holds:
  - SEL_ARITH=2'b00, SEL_CMP=2'b01, SEL_LOGIC=2'b10, SEL_NONE=2'b11, shared with the result mux.
  - State encoding IDLE/ISSUE/WAIT/DONE.
  - Default DATA_W.
- One natural sub-module: dispatch_timeout_ctr, a counter with clear, enable and a terminal-count flag, parameterised by TIMEOUT.
- The FSM, strobe decode and result capture stay in the top module.

Test Plan:
- sel=00, a=8'h7F, b=8'h01; arith_done one cycle after arith_start with arith_res=9'h080 -> exactly one arith_start pulse, res_valid 3 cycles after acceptance, res=9'h080, err=0.
- sel=11, a=8'hAA -> no start strobe; res_valid the next cycle with res=0, err=0; res_ready held low 5 cycles -> res and res_valid stay stable, req_ready stays 0.
- sel=01 with cmp_done never asserted, TIMEOUT=16 -> res_valid after the ISSUE cycle plus 16 WAIT cycles, res=0, err=1; the next request is accepted normally.
- sel=10 with arith_done and cmp_done pulsed during WAIT, then logic_done with logic_res=9'h0F0 -> stray dones ignored; res=9'h0F0, err=0.
- reset asserted during WAIT of a sel=00 request, then arith_done pulsed after reset -> all outputs at reset values, res_valid never rises, req_ready=1 the cycle after reset deasserts.
- Done coincides with the timeout cycle (cmp_done on the 16th WAIT cycle, cmp_res=9'h1FF) -> res=9'h1FF, err=0.
